// File: rtl/divider_controller.sv
// +----------------------------------------------------------------------------+
// | Module  : divider_controller                                               |
// | Purpose : Run/stop sequencer and period-safe reconfiguration front-end     |
// |           for a modulo-M clock-enable divider (tick + square wave).        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module divider_controller #(
   parameter int WIDTH       = 25,
   parameter int DEFAULT_DIV = 25_000_000,
   parameter int CNT_W       = 8
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_ticks,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             tick,
   output logic             div_frec,
   output logic             running,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   ticks_q, ticks_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   sh_div_q, sh_div_d;
   logic [CNT_W-1:0]   sh_ticks_q, sh_ticks_d;
   logic               tick_q, tick_d;
   logic               frec_q, frec_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               running_q, running_d;

   logic               w_xfer;
   logic               w_bad;
   logic               w_good;
   logic               w_tc;
   logic               w_last;

   assign cfg_ready = (state_q != S_PEND);
   assign w_xfer    = cfg_valid && cfg_ready;
   assign w_bad     = (cfg_div < WIDTH'(2));
   assign w_good    = w_xfer && !w_bad;
   assign w_tc      = (cnt_q == div_q - WIDTH'(1));
   assign w_last    = (rem_q == CNT_W'(1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      ticks_d    = ticks_q;
      rem_d      = rem_q;
      sh_div_d   = sh_div_q;
      sh_ticks_d = sh_ticks_q;
      tick_d     = 1'b0;
      frec_d     = frec_q;
      done_d     = 1'b0;
      err_d      = w_xfer && w_bad;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (w_good) begin
               div_d   = cfg_div;
               ticks_d = cfg_ticks;
            end
            if (start && !stop) begin
               state_d = S_RUN;
               rem_d   = ticks_q;
            end
         end
         S_RUN, S_PEND: begin
            if (stop) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               frec_d  = 1'b0;
               if (state_q == S_PEND) begin
                  div_d   = sh_div_q;
                  ticks_d = sh_ticks_q;
               end
               // A fresh offer accepted at the same edge is newer than the shadow.
               if (w_good) begin
                  div_d   = cfg_div;
                  ticks_d = cfg_ticks;
               end
            end else begin
               cnt_d = w_tc ? '0 : cnt_q + WIDTH'(1);
               if (w_tc) begin
                  tick_d = 1'b1;
                  frec_d = !frec_q;
                  if (rem_q != '0) begin
                     rem_d = rem_q - CNT_W'(1);
                  end
                  if (state_q == S_PEND) begin
                     div_d   = sh_div_q;
                     ticks_d = sh_ticks_q;
                     state_d = S_RUN;
                  end
                  if (w_last) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
               if (w_good) begin
                  // Burst ends at this edge: nothing left to protect, load directly.
                  if (w_tc && w_last) begin
                     div_d   = cfg_div;
                     ticks_d = cfg_ticks;
                  end else begin
                     sh_div_d   = cfg_div;
                     sh_ticks_d = cfg_ticks;
                     state_d    = S_PEND;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      running_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         div_q      <= WIDTH'(DEFAULT_DIV);
         ticks_q    <= '0;
         rem_q      <= '0;
         sh_div_q   <= '0;
         sh_ticks_q <= '0;
         tick_q     <= 1'b0;
         frec_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         ticks_q    <= ticks_d;
         rem_q      <= rem_d;
         sh_div_q   <= sh_div_d;
         sh_ticks_q <= sh_ticks_d;
         tick_q     <= tick_d;
         frec_q     <= frec_d;
         done_q     <= done_d;
         err_q      <= err_d;
         running_q  <= running_d;
      end
   end

   assign tick     = tick_q;
   assign div_frec = frec_q;
   assign done     = done_q;
   assign cfg_err  = err_q;
   assign running  = running_q;

endmodule

`default_nettype wire

// File: tb/tb_divider_controller.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_divider_controller                                            |
// | Purpose : Directed self-checking bench for divider_controller.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_divider_controller;

   localparam int WIDTH       = 25;
   localparam int DEFAULT_DIV = 4;
   localparam int CNT_W       = 8;

   logic             clk_in = 1'b0;
   logic             reset_n;
   logic             start;
   logic             stop;
   logic             cfg_valid;
   logic [WIDTH-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_ticks;
   logic             cfg_ready;
   logic             cfg_err;
   logic             tick;
   logic             div_frec;
   logic             running;
   logic             done;

   int errors = 0;
   int checks = 0;

   divider_controller #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .start    (start),
      .stop     (stop),
      .cfg_valid(cfg_valid),
      .cfg_div  (cfg_div),
      .cfg_ticks(cfg_ticks),
      .cfg_ready(cfg_ready),
      .cfg_err  (cfg_err),
      .tick     (tick),
      .div_frec (div_frec),
      .running  (running),
      .done     (done)
   );

   always #5 clk_in = ~clk_in;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic load_cfg(input int d, input int t);
      cfg_valid = 1'b1;
      cfg_div   = WIDTH'(d);
      cfg_ticks = CNT_W'(t);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] tk;
      reset_n = 1'b0;
      start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_ticks = '0;
      repeat (3) @(posedge clk_in);
      #1;
      reset_n = 1'b1;
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
      checks++;
      if (div_frec !== 1'b0) begin errors++; $display("FAIL reset_frec: got %b expected 0", div_frec); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
      checks++;
      if ({done, cfg_err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b expected 00", {done, cfg_err}); end
      pulse_start();
      tk = '0;
      for (int i = 1; i <= 9; i++) begin
         step();
         tk[i] = tick;
      end
      checks++;
      if (tk !== 32'h0000_0110) begin errors++; $display("FAIL reset_default_ticks: got %h expected %h", tk, 32'h110); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if ({running, div_frec, tick} !== 3'b000) begin errors++; $display("FAIL stop_outputs: got %b expected 000", {running, div_frec, tick}); end
   endtask

   task automatic test_continuous();
      logic [31:0] tk, fr, rn;
      load_cfg(5, 0);
      pulse_start();
      tk = '0; fr = '0; rn = '0;
      for (int i = 1; i <= 21; i++) begin
         step();
         tk[i] = tick;
         fr[i] = div_frec;
         rn[i] = running;
      end
      checks++;
      if (tk !== 32'h0010_8420) begin errors++; $display("FAIL cont_ticks: got %h expected %h", tk, 32'h0010_8420); end
      checks++;
      if (fr !== 32'h000F_83E0) begin errors++; $display("FAIL cont_frec: got %h expected %h", fr, 32'h000F_83E0); end
      checks++;
      if (rn !== 32'h003F_FFFE) begin errors++; $display("FAIL cont_running: got %h expected %h", rn, 32'h003F_FFFE); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if ({running, div_frec, done} !== 3'b000) begin errors++; $display("FAIL cont_stop: got %b expected 000", {running, div_frec, done}); end
   endtask

   task automatic test_burst();
      logic [31:0] tk, dn, rn, fr;
      load_cfg(4, 3);
      pulse_start();
      tk = '0; dn = '0; rn = '0; fr = '0;
      for (int i = 1; i <= 16; i++) begin
         step();
         tk[i] = tick; dn[i] = done; rn[i] = running; fr[i] = div_frec;
      end
      checks++;
      if (tk !== 32'h0000_1110) begin errors++; $display("FAIL burst_ticks: got %h expected %h", tk, 32'h1110); end
      checks++;
      if (dn !== 32'h0000_1000) begin errors++; $display("FAIL burst_done: got %h expected %h", dn, 32'h1000); end
      checks++;
      if (rn !== 32'h0000_0FFE) begin errors++; $display("FAIL burst_running: got %h expected %h", rn, 32'h0FFE); end
      checks++;
      if (fr !== 32'h0001_F0F0) begin errors++; $display("FAIL burst_frec: got %h expected %h", fr, 32'h1F0F0); end
      pulse_start();
      tk = '0; dn = '0; fr = '0;
      for (int i = 1; i <= 16; i++) begin
         step();
         tk[i] = tick; dn[i] = done; fr[i] = div_frec;
      end
      checks++;
      if (tk !== 32'h0000_1110) begin errors++; $display("FAIL burst2_ticks: got %h expected %h", tk, 32'h1110); end
      checks++;
      if (dn !== 32'h0000_1000) begin errors++; $display("FAIL burst2_done: got %h expected %h", dn, 32'h1000); end
      checks++;
      if (fr !== 32'h0000_0F0E) begin errors++; $display("FAIL burst2_frec: got %h expected %h", fr, 32'h0F0E); end
   endtask

   task automatic test_illegal();
      logic [31:0] tk, dn;
      cfg_valid = 1'b1;
      cfg_div   = WIDTH'(1);
      cfg_ticks = CNT_W'(0);
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", cfg_ready); end
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse: got %b expected 1", cfg_err); end
      step();
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear: got %b expected 0", cfg_err); end
      pulse_start();
      tk = '0; dn = '0;
      for (int i = 1; i <= 14; i++) begin
         step();
         tk[i] = tick; dn[i] = done;
      end
      checks++;
      if (tk !== 32'h0000_1110) begin errors++; $display("FAIL illegal_keeps_div: got %h expected %h", tk, 32'h1110); end
      checks++;
      if (dn !== 32'h0000_1000) begin errors++; $display("FAIL illegal_keeps_ticks: got %h expected %h", dn, 32'h1000); end
   endtask

   task automatic test_live_reconfig();
      logic [31:0] tk, rd;
      load_cfg(4, 0);
      pulse_start();
      tk = '0; rd = '0;
      for (int i = 0; i <= 20; i++) begin
         tk[i] = tick;
         rd[i] = cfg_ready;
         cfg_valid = (i == 1);
         cfg_div   = WIDTH'(6);
         cfg_ticks = CNT_W'(0);
         step();
      end
      cfg_valid = 1'b0;
      checks++;
      if (tk !== 32'h0001_0410) begin errors++; $display("FAIL live_ticks: got %h expected %h", tk, 32'h10410); end
      checks++;
      if (rd !== 32'h001F_FFF3) begin errors++; $display("FAIL live_ready: got %h expected %h", rd, 32'h1FFFF3); end
   endtask

   task automatic test_abort();
      bit   found;
      logic seen;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (div_frec === 1'b1) found = 1'b1;
         else step();
      end
      checks++;
      if (!found) begin errors++; $display("FAIL abort_wait_frec: got timeout expected div_frec=1 within 20 cycles"); end
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL abort_pre_running: got %b expected 1", running); end
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      checks++;
      if ({running, div_frec, tick, done} !== 4'b0000) begin
         errors++; $display("FAIL abort_outputs: got %b expected 0000", {running, div_frec, tick, done});
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen = seen | tick | done | running;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", seen); end
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] tk;
      logic        seen;
      load_cfg(3, 2);
      pulse_start();
      repeat (4) step();
      checks++;
      if ({running, div_frec} !== 2'b11) begin errors++; $display("FAIL midrst_pre: got %b expected 11", {running, div_frec}); end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({tick, div_frec, done, cfg_err, running, cfg_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL midrst_clear: got %b expected 000001", {tick, div_frec, done, cfg_err, running, cfg_ready});
      end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         seen = seen | done | tick;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b expected 0", seen); end
      reset_n = 1'b1;
      pulse_start();
      tk = '0;
      for (int i = 1; i <= 9; i++) begin
         step();
         tk[i] = tick;
      end
      checks++;
      if (tk !== 32'h0000_0110) begin errors++; $display("FAIL midrst_default_div: got %h expected %h", tk, 32'h110); end
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL midrst_continuous: got %b expected 1", running); end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_burst();
      test_illegal();
      test_live_reconfig();
      test_abort();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/divider_controller.md
Name: divider_controller

Overview:
- Run/stop sequencer and safe reconfiguration front-end for the modulo-M clock-enable divider used across the design.
- Owns a programmable divide ratio and generates one-cycle enable ticks plus a square wave, either continuously or as a finite burst.
- Divider reconfiguration happens over a valid/ready handshake and takes effect only on period boundaries, so consumers never see a truncated period.

Parameters:
- WIDTH, 25, width of the divide-ratio register and the period counter.
- DEFAULT_DIV, 25_000_000, divide ratio loaded at reset; must be in the range 2..2^WIDTH-1.
- CNT_W, 8, width of the burst tick-count field.

Ports:
- clk_in  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle request to begin counting.
- stop  in  1  1-cycle request to abort counting.
- cfg_valid  in  1  configuration offer.
- cfg_div  in  WIDTH  requested divide ratio; legal values are 2..2^WIDTH-1.
- cfg_ticks  in  CNT_W  burst length; 0 selects continuous mode.
- cfg_ready  out  1  controller can accept a configuration this cycle.
- cfg_err  out  1  1-cycle pulse: accepted configuration was rejected because cfg_div < 2.
- tick  out  1  1-cycle enable pulse, once per divide period.
- div_frec  out  1  square wave; toggles on every tick, so its period is 2*div.
- running  out  1  high while the state is RUN or PENDING.
- done  out  1  1-cycle pulse on the final tick of a burst.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, counter=0, div_reg=DEFAULT_DIV, ticks_reg=0, remaining=0, shadow registers cleared.
  - tick=0, div_frec=0, done=0, cfg_err=0, running=0, cfg_ready=1.
  - Reset asserted mid-operation clears everything immediately; no done pulse is produced.
- All outputs are registered except cfg_ready, which is decoded from state: 1 in IDLE and RUN, 0 in PENDING.
- Handshake: a configuration is transferred when cfg_valid && cfg_ready at a rising edge.
  - cfg_div < 2: cfg_err pulses on the next cycle; div_reg, ticks_reg and state are unchanged; the transfer is still consumed.
  - Valid configuration in IDLE: div_reg<=cfg_div and ticks_reg<=cfg_ticks at that edge.
  - Valid configuration in RUN: the values go into shadow registers and the state moves to PENDING.
- States:
  - IDLE: counter held at 0. start moves to RUN with counter<=0 and remaining<=ticks_reg.
  - RUN: counter increments every cycle. At counter==div_reg-1: counter<=0, tick<=1, div_frec toggles. In burst mode remaining also decrements.
  - PENDING: counts exactly like RUN. At the next terminal count the shadow values are copied to div_reg/ticks_reg, the state returns to RUN, and the new ratio governs the following period.
- Timing:
  - If start is sampled at edge k, tick is high in the cycle after edge k+div_reg.
  - The first tick therefore occurs div_reg cycles after start; subsequent ticks are exactly div_reg cycles apart.
- Burst mode (remaining != 0 at start):
  - On the tick where remaining goes 1->0, done pulses in the same cycle as that tick.
  - The state goes to IDLE at the same edge, so running drops with the tick.
  - A pending shadow configuration is applied at that edge.
- Continuous mode: remaining is unused; ticks continue until stop.
- ticks_reg changes only affect the next start; remaining is never reloaded mid-run.
- stop in RUN or PENDING:
  - Next state IDLE, counter<=0; no tick, no done.
  - div_frec<=0.
  - A pending shadow configuration is applied, not discarded.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - start while running: ignored.
  - stop in IDLE: ignored.
  - Configuration accepted in the same cycle as a terminal count in RUN: goes to the shadow registers and applies at the next terminal count, not the current one.
- Arithmetic: the counter is WIDTH bits and never exceeds div_reg-1, so no wrap beyond the terminal count. remaining is CNT_W bits and saturates at 0.

Test Plan:
- Reset check (DEFAULT_DIV=4): hold reset_n=0 for 3 cycles, then release -> tick=0, div_frec=0, running=0, cfg_ready=1; start -> ticks at +4 and +8.
- Continuous run: in IDLE load cfg_div=5, cfg_ticks=0, then start -> tick at cycles 5, 10, 15, 20; div_frec period 10; running stays 1 until stop.
- Burst: load cfg_div=4, cfg_ticks=3, then start -> ticks at 4, 8, 12; done coincides with the tick at 12; running=0 from cycle 12; a further start gives another 3 ticks.
- Live reconfiguration: run with div=4, offer cfg_div=6 at cycle 2 -> cfg_ready=0 until the tick at 4; next ticks at 10 and 16.
- Illegal ratio: offer cfg_div=1 in IDLE -> cfg_err pulses once; div_reg unchanged (ticks remain 4 apart); cfg_ready stays 1.
- Aborts:
  - Assert start and stop together during a run -> IDLE, div_frec=0, no done.
  - Drive reset_n low mid-burst with one tick remaining -> all outputs clear immediately; no done pulse.
